// File: rtl/switch_debouncer.sv
// Player switch-bank conditioner: two-flop synchroniser, a persistence counter per bit, and a
// registered one-cycle change event (mask, lowest index, direction, multi-change flag).
module switch_debouncer #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned IDX_W           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch_stable,
  output logic [WIDTH-1:0] changed_bit,
  output logic             change_valid,
  output logic [IDX_W-1:0] change_idx,
  output logic             change_dir,
  output logic             multi_change
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned PopW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             multi_q, multi_d;
  logic [PopW-1:0]  pop;

  // Persistence counters: any agreement with the stable value restarts the count.
  always_comb begin
    stable_d  = stable_q;
    changed_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i]  = sync2_q[i];
          changed_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Event fields are derived from next-state values so they register alongside the mask.
  always_comb begin
    idx_d = '0;
    dir_d = 1'b0;
    pop   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (changed_d[i]) begin
        idx_d = IDX_W'(i);
        dir_d = stable_d[i];
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PopW'(changed_d[i]);
    end
    valid_d = |changed_d;
    multi_d = (pop > PopW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      changed_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      dir_q     <= 1'b0;
      multi_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= switch_raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      changed_q <= changed_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      dir_q     <= dir_d;
      multi_q   <= multi_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign switch_stable = stable_q;
  assign changed_bit   = changed_q;
  assign change_valid  = valid_q;
  assign change_idx    = idx_q;
  assign change_dir    = dir_q;
  assign multi_change  = multi_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with DEBOUNCE_CYCLES=4: directed scenarios followed by random
// bouncing, all compared every cycle against a sliding-window reference model.
module tb_switch_debouncer;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] switch_raw = '0;
  logic [W-1:0] switch_stable, changed_bit;
  logic         change_valid, change_dir, multi_change;
  logic [2:0]   change_idx;

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .IDX_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switch_raw(switch_raw),
    .switch_stable(switch_stable),
    .changed_bit(changed_bit),
    .change_valid(change_valid),
    .change_idx(change_idx),
    .change_dir(change_dir),
    .multi_change(multi_change)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a change is accepted once the last D synchronised samples since reset all
  // disagree with the stable value; synchronised sample = raw delayed by two edges.
  logic [W-1:0] d1 = '0, d2 = '0;
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable = '0, m_changed = '0;
  logic         m_valid = 1'b0, m_dir = 1'b0, m_multi = 1'b0;
  logic [2:0]   m_idx = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [W-1:0] s2;
    bit all_diff;
    if (rst) begin
      d1 = '0;
      d2 = '0;
      hist.delete();
      m_stable  = '0;
      m_changed = '0;
    end else begin
      s2 = d2;
      d2 = d1;
      d1 = switch_raw;
      hist.push_back(s2);
      if (hist.size() > D) void'(hist.pop_front());
      m_changed = '0;
      if (hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
          m_changed[b] = all_diff;
        end
      end
      m_stable = m_stable ^ m_changed;
    end
    m_valid = (m_changed != '0);
    m_idx   = '0;
    for (int b = W - 1; b >= 0; b--) if (m_changed[b]) m_idx = 3'(b);
    m_dir   = m_valid ? m_stable[m_idx] : 1'b0;
    m_multi = ($countones(m_changed) > 1);
  endtask

  // One clock: model consumes pre-edge inputs, then all outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("stable", 32'(switch_stable), 32'(m_stable));
    check("changed", 32'(changed_bit), 32'(m_changed));
    check("valid", 32'(change_valid), 32'(m_valid));
    check("idx", 32'(change_idx), 32'(m_idx));
    check("dir", 32'(change_dir), 32'(m_dir));
    check("multi", 32'(multi_change), 32'(m_multi));
  endtask

  initial begin
    bit saw_valid;

    // Switches held high through reset become a single all-bits 0->1 event.
    rst = 1'b1;
    switch_raw = 8'hFF;
    tick();
    tick();
    check("reset_stable", 32'(switch_stable), 32'h0);
    check("reset_valid", 32'(change_valid), 32'h0);
    rst = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check("post_reset_quiet", 32'(changed_bit), 32'h0);
    end
    tick();
    check("post_reset_mask", 32'(changed_bit), 32'hFF);
    check("post_reset_multi", 32'(multi_change), 32'h1);
    check("post_reset_dir", 32'(change_dir), 32'h1);
    tick();
    check("post_reset_pulse", 32'(changed_bit), 32'h0);

    // Clean single-bit rise on the highest bit.
    switch_raw = 8'h00;
    repeat (8) tick();
    switch_raw = 8'h80;
    for (int t = 1; t <= 5; t++) tick();
    tick();
    check("b7_stable", 32'(switch_stable), 32'h80);
    check("b7_idx", 32'(change_idx), 32'h7);
    check("b7_multi", 32'(multi_change), 32'h0);
    tick();
    check("b7_valid_drop", 32'(change_valid), 32'h0);

    // Bit 1 bounces with period 4: never long enough to be accepted.
    saw_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      switch_raw[1] = ((c >> 1) & 1) == 0;
      tick();
      if (change_valid) saw_valid = 1'b1;
    end
    switch_raw[1] = 1'b0;
    repeat (8) begin
      tick();
      if (change_valid) saw_valid = 1'b1;
    end
    check("bounce_no_event", 32'(saw_valid), 32'h0);
    check("bounce_stable", 32'(switch_stable), 32'h80);

    // Falling edge on bit 1.
    switch_raw = 8'h82;
    repeat (8) tick();
    switch_raw = 8'h80;
    for (int t = 1; t <= 6; t++) tick();
    check("b1_fall_stable", 32'(switch_stable), 32'h80);
    check("b1_fall_idx", 32'(change_idx), 32'h1);
    check("b1_fall_dir", 32'(change_dir), 32'h0);

    // Staggered changes give two separate single-bit events three cycles apart.
    switch_raw = 8'h81;
    for (int t = 1; t <= 12; t++) begin
      if (t == 4) switch_raw = 8'h85;
      tick();
      if (t == 6 || t == 9) begin
        check("stagger_valid", 32'(change_valid), 32'h1);
        check("stagger_idx", 32'(change_idx), (t == 6) ? 32'h0 : 32'h2);
        check("stagger_multi", 32'(multi_change), 32'h0);
      end else begin
        check("stagger_quiet", 32'(change_valid), 32'h0);
      end
    end

    // Reset in the middle of bit 3's count discards it; counting restarts afterwards.
    switch_raw = 8'h80;
    repeat (8) tick();
    switch_raw = 8'h88;
    for (int t = 1; t <= 4; t++) tick();
    rst = 1'b1;
    tick();
    check("midreset_valid", 32'(change_valid), 32'h0);
    rst = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check("midreset_quiet", 32'(change_valid), 32'h0);
    end
    tick();
    check("midreset_mask", 32'(changed_bit), 32'h88);

    // Random bouncing with occasional long holds and rare resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) switch_raw[$urandom_range(0, W - 1)] ^= 1'b1;
      if ($urandom_range(0, 40) == 0) switch_raw = 8'($urandom);
      rst = ($urandom_range(0, 400) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the raw 8-bit player switch bank before it reaches hit_or_miss.
- Synchronises each bit and debounces it with a per-bit persistence counter.
- Emits a clean stable switch vector plus a one-cycle change event: mask, lowest index, direction and multi-change flag.
- Outputs `switch_stable` and `changed_bit` connect directly to hit_or_miss `switch` / `changed_bit_wire`.

Parameters:
- WIDTH, 8, number of switch bits.
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised bit must disagree with its stable value before the change is accepted.
  - Must be ≥ 1.
  - Benches override it to 4.
- IDX_W, 3, width of `change_idx`; must be ≥ $clog2(WIDTH).

Ports:
- clk, input, 1, system clock; all logic rising-edge.
- rst, input, 1, synchronous active-high reset.
- switch_raw, input, WIDTH, asynchronous, bouncy switch pins.
- switch_stable, output, WIDTH, debounced switch state (registered).
- changed_bit, output, WIDTH, one-cycle mask of bits whose stable value flipped this cycle.
- change_valid, output, 1, OR-reduction of `changed_bit` (registered).
- change_idx, output, IDX_W, index of lowest set bit of `changed_bit`; 0 when `change_valid`=0.
- change_dir, output, 1, new stable value of bit `change_idx`; 0 when `change_valid`=0.
- multi_change, output, 1, high when more than one bit flipped in the same cycle.

Behaviour:
- Reset (rst high at a rising edge) clears:
  - sync1, sync2, every counter, `switch_stable`, `changed_bit`, `change_valid`, `change_idx`, `change_dir` and `multi_change`, all to 0.
  - Reset has priority over all other logic.
  - Reset mid-debounce discards the partial count; no event is emitted.
- Synchroniser: a two-flop chain per bit, `switch_raw` → sync1 → sync2. Only sync2 feeds the debounce logic.
- Per-bit counter `cnt[i]`, width $clog2(DEBOUNCE_CYCLES)+1. Each edge:
  - If `sync2[i]` == `switch_stable[i]`: `cnt[i]` <= 0.
  - Else if `cnt[i]` == DEBOUNCE_CYCLES-1: `switch_stable[i]` <= `sync2[i]`, `cnt[i]` <= 0, `changed_bit[i]` <= 1.
  - Else: `cnt[i]` <= `cnt[i]`+1.
- `changed_bit[i]` is 0 in every cycle it is not set by the rule above, so it is a single-cycle pulse.
- Glitches: any return of `sync2[i]` to the stable value before the count completes clears the count. A bounce shorter than DEBOUNCE_CYCLES never produces an event.
- Latency:
  - Raw change applied before edge E0.
  - `switch_stable` and `changed_bit` update at edge E0+DEBOUNCE_CYCLES+1, i.e. the (DEBOUNCE_CYCLES+2)-th edge counting E0 as the first.
  - `change_valid`, `change_idx`, `change_dir` and `multi_change` are registered in the same edge as `changed_bit`, computed from next-state values, so all event outputs are coherent in one cycle.
- Priority: `change_idx` is the lowest flipped index. `multi_change` = popcount(next `changed_bit`) > 1.
- Independence: bits debounce independently. Simultaneous changes on several bits that settle together produce one event cycle with several mask bits set.
- Level at reset: stable is forced to 0 on reset. A switch held high through reset is reported as a 0→1 event DEBOUNCE_CYCLES+2 edges after reset falls.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.

Test Plan (DEBOUNCE_CYCLES=4):
- Hold rst 2 cycles with `switch_raw`=8'hFF → all outputs 0 during reset. After release, `switch_stable`=8'hFF on edge 6 after release, with `changed_bit`=8'hFF, `change_idx`=0, `change_dir`=1, `multi_change`=1 for exactly one cycle.
- From 0, set `switch_raw`=8'h80 cleanly → on the 6th edge `switch_stable`=8'h80, `changed_bit`=8'h80, `change_valid`=1, `change_idx`=7, `change_dir`=1, `multi_change`=0. Next cycle `changed_bit`=0 and `change_valid`=0.
- Bit 1 toggles 0/1 every 2 cycles for 20 cycles, then returns to 0 → `switch_stable[1]` stays 0 and `change_valid` never asserts.
- Stable at 8'h82, clear bit 1 → `switch_stable`=8'h80, `change_idx`=1, `change_dir`=0 on the 6th edge.
- Bit 0 set, then 3 cycles later bit 2 set → two separate single-bit events, 3 cycles apart, with `change_idx` 0 then 2 and `multi_change`=0 both times.
- Assert rst for one cycle while bit 3 is mid-count (`cnt`=2) → no event is ever emitted for that count. Counting restarts after reset, and the event fires 6 edges after rst falls.
